tlk2711_tx_sched: RTL and testbench
===================================

Name: tlk2711_tx_sched

Overview:
- TX packet scheduler sitting directly downstream of the register block, in the clk domain.
- On a tx config-done strobe it latches the TX configuration and splits the file into DMA read commands: body_num bodies of packet_body bytes, then one tail of packet_tail bytes if non-zero.
- Tracks outstanding packets against packet-done pulses from the framer.
- Issues the single-cycle tx_interrupt that the register block reports to the CPU.

Parameters:
- ADDR_WIDTH, 32, DDR byte-address width.
- MAX_OUTSTANDING, 4, maximum commands issued but not yet done (1..7).
- WDOG_CYCLES, 16'hFFFF, watchdog limit in clk cycles (used only with TX_SCHED_WDOG_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_tx_config_done  in  1  single-cycle start strobe
- i_tx_base_addr  in  ADDR_WIDTH  first byte address
- i_tx_packet_body  in  16  body length in bytes
- i_tx_body_num  in  16  number of bodies
- i_tx_packet_tail  in  16  tail length in bytes; 0 = no tail
- i_tx_mode  in  4  0 = norm, 1 = loopback, 2 = kcode, others reserved
- o_dma_cmd_valid  out  1  command valid
- i_dma_cmd_ready  in  1  command accept
- o_dma_cmd_addr  out  ADDR_WIDTH  command address
- o_dma_cmd_len  out  16  command length in bytes
- o_dma_cmd_last  out  1  marks the final command of the file
- i_pkt_done  in  1  single-cycle pulse: one packet fully transmitted
- o_kcode_en  out  1  kcode idle-pattern enable
- o_tx_interrupt  out  1  single-cycle file-complete pulse
- o_tx_status  out  10  status word
- o_timeout  out  1  single-cycle watchdog abort pulse

Behaviour:
- Reset: clk/rst are the already-decided synchronous active-high reset and clock. All outputs are 0, state = IDLE, counters = 0, sticky bits cleared. A reset mid-operation drops o_dma_cmd_valid in the same edge. Commands that have been issued are forgotten.
- States, encoded in o_tx_status[2:0]: IDLE=0, ISSUE=1, WAIT=2, DONE=3, KCODE=4.
- IDLE + config_done:
  - Latch all inputs and clear sticky bits [5:3].
  - If mode > 2, or (body_num > 0 and packet_body == 0), or (body_num == 0 and tail == 0): set cfg_err [3], stay IDLE, issue no command and no interrupt.
  - Else if mode == 2: go to KCODE, o_kcode_en = 1 the next cycle.
  - Else: go to ISSUE.
- ISSUE:
  - o_dma_cmd_valid is asserted whenever outstanding < MAX_OUTSTANDING.
  - addr/len/last stay stable while valid && !ready; valid is never withdrawn without a handshake, except on rst.
  - Length is packet_body for commands 0..body_num-1, then packet_tail.
  - On handshake: addr += len (modulo 2^ADDR_WIDTH wrap), outstanding++.
  - o_dma_cmd_last = 1 on the final command.
  - After the last handshake, go to WAIT.
  - Next command valid at earliest the cycle after a handshake, so throughput is one command per 2 cycles.
- Outstanding counter (3 bits):
  - Handshake and i_pkt_done in the same cycle: no change.
  - i_pkt_done with outstanding == 0: ignored, set spurious [5].
- WAIT: when outstanding == 0, go to DONE.
- DONE: o_tx_interrupt = 1 for exactly one cycle, then go to IDLE. Interrupt latency is 1 cycle after the last i_pkt_done.
- KCODE:
  - o_kcode_en = 1, no commands issued.
  - config_done is accepted as in IDLE, with o_kcode_en deasserted the same cycle the new config is latched.
- Overrun: config_done in ISSUE/WAIT/DONE is ignored and sets overrun [4].
- o_tx_status layout: [2:0] state, [3] cfg_err, [4] overrun, [5] spurious_done, [6] o_kcode_en, [9:7] outstanding.

Optional Feature:
- TX_SCHED_WDOG_EN defined:
  - A 16-bit counter runs in ISSUE/WAIT and resets on any handshake or i_pkt_done.
  - At WDOG_CYCLES: pulse o_timeout for 1 cycle, set cfg_err, clear outstanding, drop valid, go to IDLE with no tx_interrupt.
- Undefined: o_timeout is tied to 0, no counter logic exists.

Test Plan:
1. Nominal file:
   - Stimulus: base=0x1000_0000, body=870, num=3, tail=100, mode 0, ready always 1, pkt_done 5 cycles after each command.
   - Required: 4 commands at addr 0x1000_0000/0x1000_0366/0x1000_06CC/0x1000_0A32 with len 870/870/870/100, last only on the 4th, exactly one tx_interrupt 1 cycle after the 4th done.
2. Backpressure and outstanding limit:
   - Stimulus: num=6, tail=0, MAX_OUTSTANDING=4, no pkt_done for 50 cycles, ready toggling.
   - Required: exactly 4 commands issued, status[9:7]=4, valid low. After 2 done pulses, 2 more commands issue with addr/len stable during !ready.
3. Config errors:
   - Stimulus: body=0 with num=2; separately num=0 with tail=0; separately mode=5.
   - Required: no command, no interrupt, status[3]=1, state IDLE.
4. Overrun, simultaneous events and wrap:
   - Stimulus: config_done during WAIT; handshake and pkt_done in the same cycle; base=0xFFFF_FF00, body=512, num=2.
   - Required: overrun bit set and config ignored; outstanding unchanged; 2nd command address is 0x0000_0100.
5. Kcode mode and reset:
   - Stimulus: mode=2; then a new config with mode 0, body=16, num=1; then rst asserted while valid=1.
   - Required: kcode_en=1 with no commands; kcode_en=0 and one command issued; all outputs 0 one cycle after rst.
6. Watchdog (TX_SCHED_WDOG_EN, WDOG_CYCLES=100):
   - Stimulus: one command issued, no pkt_done.
   - Required: o_timeout pulses 100 cycles after the last progress, state IDLE, status[3]=1, no tx_interrupt.

Source files
------------

// File: rtl/tlk2711_tx_sched.sv
// rtl/tlk2711_tx_sched.sv - TLK2711 TX packet scheduler: splits a file into DMA read commands and tracks completion
//
// Optional build macro: TX_SCHED_WDOG_EN enables the progress watchdog (o_timeout); otherwise o_timeout is tied to 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_tx_config_done         start strobe; latches base/body/num/tail/mode
//   i_tx_base_addr           first DDR byte address of the file
//   i_tx_packet_body/_tail   body and tail lengths in bytes (tail 0 = none)
//   i_tx_body_num            number of body packets
//   i_tx_mode                0 norm, 1 loopback, 2 kcode, others reserved
//   o_dma_cmd_*              DMA read command (valid/ready, addr, len, last)
//   i_pkt_done               one packet fully sent by the framer
//   o_kcode_en               kcode idle-pattern enable
//   o_tx_interrupt           one-cycle file-complete pulse
//   o_tx_status              {outstanding[2:0], kcode_en, spurious, overrun, cfg_err, state[2:0]}
//   o_timeout                one-cycle watchdog abort pulse
module tlk2711_tx_sched #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [15:0] WDOG_CYCLES     = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tx_config_done,
  input  logic [ADDR_WIDTH-1:0] i_tx_base_addr,
  input  logic [15:0]           i_tx_packet_body,
  input  logic [15:0]           i_tx_body_num,
  input  logic [15:0]           i_tx_packet_tail,
  input  logic [3:0]            i_tx_mode,
  output logic                  o_dma_cmd_valid,
  input  logic                  i_dma_cmd_ready,
  output logic [ADDR_WIDTH-1:0] o_dma_cmd_addr,
  output logic [15:0]           o_dma_cmd_len,
  output logic                  o_dma_cmd_last,
  input  logic                  i_pkt_done,
  output logic                  o_kcode_en,
  output logic                  o_tx_interrupt,
  output logic [9:0]            o_tx_status,
  output logic                  o_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_KCODE = 3'd4;
  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           body_q, body_d, num_q, num_d, tail_q, tail_d;
  logic [16:0]           idx_q, idx_d, total_q, total_d;
  logic                  valid_q, valid_d;
  logic [2:0]            outst_q, outst_d;
  logic                  cfg_err_q, cfg_err_d, overrun_q, overrun_d, spur_q, spur_d;

  logic                  hs, cfg_bad, cmd_is_last, spur_evt, wdog_hit;
  logic [15:0]           cur_len;

  assign hs          = valid_q & i_dma_cmd_ready;
  // Commands 0..num-1 are bodies, the optional final one is the tail.
  assign cur_len     = (idx_q < {1'b0, num_q}) ? body_q : tail_q;
  assign cmd_is_last = (idx_q == total_q - 17'd1);
  assign cfg_bad     = (i_tx_mode > 4'd2)
                    || ((i_tx_body_num != 16'd0) && (i_tx_packet_body == 16'd0))
                    || ((i_tx_body_num == 16'd0) && (i_tx_packet_tail == 16'd0));

`ifdef TX_SCHED_WDOG_EN
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q;
  logic        wdog_active;

  // wdog_q counts cycles since the last handshake or packet-done.
  assign wdog_active = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign wdog_hit    = wdog_active && !(hs || i_pkt_done) && (wdog_q == WDOG_CYCLES - 16'd1);

  always_comb begin
    wdog_d = 16'd0;
    if (wdog_active) wdog_d = (hs || i_pkt_done) ? 16'd1 : wdog_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= wdog_hit;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign wdog_hit  = 1'b0;
  // WDOG_CYCLES only matters with the watchdog; referenced so it stays elaborated.
  assign o_timeout = 1'b0 & (|WDOG_CYCLES);
`endif

  // Outstanding counter: a handshake and a done in the same cycle cancel out.
  always_comb begin
    outst_d  = outst_q;
    spur_evt = 1'b0;
    if (hs && !i_pkt_done) begin
      outst_d = outst_q + 3'd1;
    end else if (!hs && i_pkt_done) begin
      if (outst_q == 3'd0) spur_evt = 1'b1;
      else                 outst_d  = outst_q - 3'd1;
    end
    if (wdog_hit) outst_d = 3'd0;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    body_d    = body_q;
    num_d     = num_q;
    tail_d    = tail_q;
    idx_d     = idx_q;
    total_d   = total_q;
    valid_d   = valid_q;
    cfg_err_d = cfg_err_q;
    overrun_d = overrun_q;
    spur_d    = spur_q | spur_evt;
    case (state_q)
      S_IDLE, S_KCODE: begin
        if (i_tx_config_done) begin
          addr_d    = i_tx_base_addr;
          body_d    = i_tx_packet_body;
          num_d     = i_tx_body_num;
          tail_d    = i_tx_packet_tail;
          idx_d     = 17'd0;
          total_d   = {1'b0, i_tx_body_num} + {16'd0, (i_tx_packet_tail != 16'd0)};
          overrun_d = 1'b0;
          spur_d    = spur_evt;
          cfg_err_d = cfg_bad;
          if (cfg_bad)                 state_d = S_IDLE;
          else if (i_tx_mode == 4'd2)  state_d = S_KCODE;
          else                         state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_tx_config_done) overrun_d = 1'b1;
        // Valid drops for one cycle after every handshake, giving one command per two cycles.
        if (hs) begin
          valid_d = 1'b0;
          addr_d  = addr_q + ADDR_WIDTH'(cur_len);
          idx_d   = idx_q + 17'd1;
          if (cmd_is_last) state_d = S_WAIT;
        end else if (!valid_q && (outst_q < MAX_OUT)) begin
          valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_tx_config_done) overrun_d = 1'b1;
        // Look at the next-state count so the interrupt lands one cycle after the final done.
        if (outst_d == 3'd0) state_d = S_DONE;
      end
      S_DONE: begin
        if (i_tx_config_done) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (wdog_hit) begin
      state_d   = S_IDLE;
      valid_d   = 1'b0;
      cfg_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      body_q    <= 16'd0;
      num_q     <= 16'd0;
      tail_q    <= 16'd0;
      idx_q     <= 17'd0;
      total_q   <= 17'd0;
      valid_q   <= 1'b0;
      outst_q   <= 3'd0;
      cfg_err_q <= 1'b0;
      overrun_q <= 1'b0;
      spur_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      body_q    <= body_d;
      num_q     <= num_d;
      tail_q    <= tail_d;
      idx_q     <= idx_d;
      total_q   <= total_d;
      valid_q   <= valid_d;
      outst_q   <= outst_d;
      cfg_err_q <= cfg_err_d;
      overrun_q <= overrun_d;
      spur_q    <= spur_d;
    end
  end

  assign o_dma_cmd_valid = valid_q;
  assign o_dma_cmd_addr  = addr_q;
  assign o_dma_cmd_len   = cur_len;
  assign o_dma_cmd_last  = valid_q & cmd_is_last;
  assign o_kcode_en      = (state_q == S_KCODE);
  assign o_tx_interrupt  = (state_q == S_DONE);
  assign o_tx_status     = {outst_q, o_kcode_en, spur_q, overrun_q, cfg_err_q, state_q};

endmodule

// File: tb/tb_tlk2711_tx_sched.sv
// tb/tb_tlk2711_tx_sched.sv - self-checking bench for tlk2711_tx_sched
module tb_tlk2711_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tx_config_done = 1'b0;
  logic [31:0] i_tx_base_addr = 32'd0;
  logic [15:0] i_tx_packet_body = 16'd0, i_tx_body_num = 16'd0, i_tx_packet_tail = 16'd0;
  logic [3:0]  i_tx_mode = 4'd0;
  logic        o_dma_cmd_valid, i_dma_cmd_ready = 1'b0, o_dma_cmd_last;
  logic [31:0] o_dma_cmd_addr;
  logic [15:0] o_dma_cmd_len;
  logic        i_pkt_done = 1'b0, o_kcode_en, o_tx_interrupt, o_timeout;
  logic [9:0]  o_tx_status;

  tlk2711_tx_sched #(.ADDR_WIDTH(32), .MAX_OUTSTANDING(4), .WDOG_CYCLES(16'd100)) dut (
    .clk(clk), .rst(rst), .i_tx_config_done(i_tx_config_done), .i_tx_base_addr(i_tx_base_addr),
    .i_tx_packet_body(i_tx_packet_body), .i_tx_body_num(i_tx_body_num), .i_tx_packet_tail(i_tx_packet_tail),
    .i_tx_mode(i_tx_mode), .o_dma_cmd_valid(o_dma_cmd_valid), .i_dma_cmd_ready(i_dma_cmd_ready),
    .o_dma_cmd_addr(o_dma_cmd_addr), .o_dma_cmd_len(o_dma_cmd_len), .o_dma_cmd_last(o_dma_cmd_last),
    .i_pkt_done(i_pkt_done), .o_kcode_en(o_kcode_en), .o_tx_interrupt(o_tx_interrupt),
    .o_tx_status(o_tx_status), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int tests_run = 0, tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder controls: ready_mode 0 = always ready, 1 = random, 2 = never.
  int ready_mode = 0, done_delay = 5, man_done_req = 0;
  bit auto_done = 1'b0;
  int due_q[$];

  // Observation log.
  logic [31:0] cmd_addr_q[$];
  logic [15:0] cmd_len_q[$];
  logic        cmd_last_q[$];
  int irq_cnt, irq_cyc, last_done_cyc, to_cnt, to_cyc, to_total = 0, stab_err, simul_cnt, simul_bad, hs_cyc;
  bit          pend = 1'b0, chk_simul = 1'b0;
  logic [31:0] p_addr;
  logic [15:0] p_len;
  logic        p_last;
  logic [2:0]  simul_ref;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       i_dma_cmd_ready = 1'b1;
      1:       i_dma_cmd_ready = 1'($urandom_range(0, 1));
      default: i_dma_cmd_ready = 1'b0;
    endcase
    i_pkt_done = 1'b0;
    while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      i_pkt_done = 1'b1;
      void'(due_q.pop_front());
    end else if (man_done_req > 0) begin
      i_pkt_done = 1'b1;
      man_done_req--;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      chk_simul = 1'b0;
    end else begin
      if (pend && (!o_dma_cmd_valid || o_dma_cmd_addr !== p_addr || o_dma_cmd_len !== p_len || o_dma_cmd_last !== p_last))
        stab_err++;
      if (chk_simul) begin
        if (o_tx_status[9:7] !== simul_ref) simul_bad++;
        chk_simul = 1'b0;
      end
      if (o_dma_cmd_valid && i_dma_cmd_ready) begin
        cmd_addr_q.push_back(o_dma_cmd_addr);
        cmd_len_q.push_back(o_dma_cmd_len);
        cmd_last_q.push_back(o_dma_cmd_last);
        hs_cyc = cyc;
        if (auto_done) due_q.push_back(cyc + done_delay);
        if (i_pkt_done) begin
          simul_cnt++;
          chk_simul = 1'b1;
          simul_ref = o_tx_status[9:7];
        end
      end
      if (i_pkt_done) last_done_cyc = cyc;
      if (o_tx_interrupt) begin irq_cnt++; irq_cyc = cyc; end
      if (o_timeout) begin to_cnt++; to_total++; to_cyc = cyc; end
      pend   = o_dma_cmd_valid && !i_dma_cmd_ready;
      p_addr = o_dma_cmd_addr;
      p_len  = o_dma_cmd_len;
      p_last = o_dma_cmd_last;
    end
  end

  task automatic clear_log();
    cmd_addr_q.delete(); cmd_len_q.delete(); cmd_last_q.delete(); due_q.delete();
    irq_cnt = 0; irq_cyc = -1; last_done_cyc = -100; to_cnt = 0; to_cyc = -1;
    stab_err = 0; simul_cnt = 0; simul_bad = 0; hs_cyc = -1; man_done_req = 0;
  endtask

  task automatic start_cfg(input logic [31:0] b, input logic [15:0] bd, input logic [15:0] nm,
                           input logic [15:0] tl, input logic [3:0] md);
    @(posedge clk); #1;
    i_tx_base_addr = b; i_tx_packet_body = bd; i_tx_body_num = nm; i_tx_packet_tail = tl; i_tx_mode = md;
    i_tx_config_done = 1'b1;
    @(posedge clk); #1;
    i_tx_config_done = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    int n = 0;
    while (irq_cnt == 0 && n < budget) begin @(negedge clk); n++; end
    tests_run++;
    if (irq_cnt == 0) begin
      tests_failed++;
      $display("FAIL irq_timeout: no tx_interrupt within %0d cycles", budget);
    end
    repeat (5) @(negedge clk);
  endtask

  // Reference: command i starts at base + i*body; bodies first, then the tail if non-zero.
  task automatic check_file(input string nm, input logic [31:0] base, input logic [15:0] body,
                            input logic [15:0] num, input logic [15:0] tail);
    int n;
    logic [31:0] ea;
    logic [15:0] el;
    logic        ex;
    n = int'(num) + ((tail != 16'd0) ? 1 : 0);
    tests_run++;
    if (cmd_addr_q.size() !== n) begin
      tests_failed++;
      $display("FAIL %s cmd_count: got %0d expected %0d", nm, cmd_addr_q.size(), n);
    end
    for (int i = 0; i < n && i < cmd_addr_q.size(); i++) begin
      ea = base + 32'(i) * 32'(body);
      el = (i < int'(num)) ? body : tail;
      ex = (i == n - 1);
      tests_run++;
      if ({cmd_addr_q[i], cmd_len_q[i], cmd_last_q[i]} !== {ea, el, ex}) begin
        tests_failed++;
        $display("FAIL %s cmd%0d: got addr=%h len=%0d last=%b expected addr=%h len=%0d last=%b",
                 nm, i, cmd_addr_q[i], cmd_len_q[i], cmd_last_q[i], ea, el, ex);
      end
    end
    tests_run++;
    if (irq_cnt !== 1) begin
      tests_failed++;
      $display("FAIL %s irq_count: got %0d expected 1", nm, irq_cnt);
    end
    tests_run++;
    if (irq_cyc !== last_done_cyc + 1) begin
      tests_failed++;
      $display("FAIL %s irq_latency: got cycle %0d expected %0d", nm, irq_cyc, last_done_cyc + 1);
    end
    tests_run++;
    if (stab_err !== 0) begin
      tests_failed++;
      $display("FAIL %s cmd_stability: got %0d violations expected 0", nm, stab_err);
    end
  endtask

  task automatic run_file(input string nm, input logic [31:0] b, input logic [15:0] bd, input logic [15:0] nmb,
                          input logic [15:0] tl, input logic [3:0] md, input int rmode, input int dly);
    clear_log();
    ready_mode = rmode; auto_done = 1'b1; done_delay = dly;
    start_cfg(b, bd, nmb, tl, md);
    wait_irq(3000);
    check_file(nm, b, bd, nmb, tl);
  endtask

  task automatic check_outputs_zero(input string nm);
    tests_run++;
    if ({o_dma_cmd_valid, o_dma_cmd_addr, o_dma_cmd_len, o_dma_cmd_last, o_kcode_en, o_tx_interrupt, o_tx_status, o_timeout} !== '0) begin
      tests_failed++;
      $display("FAIL %s outputs_zero: got valid=%b addr=%h len=%0d last=%b kcode=%b irq=%b status=%h timeout=%b expected all 0",
               nm, o_dma_cmd_valid, o_dma_cmd_addr, o_dma_cmd_len, o_dma_cmd_last, o_kcode_en, o_tx_interrupt, o_tx_status, o_timeout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_reset");
  endtask

  task automatic test_nominal();
    logic [15:0] nb, tl;
    run_file("nominal", 32'h1000_0000, 16'd870, 16'd3, 16'd100, 4'd0, 0, 5);
    for (int k = 0; k < 6; k++) begin
      nb = 16'($urandom_range(0, 5));
      tl = (nb == 16'd0) ? 16'($urandom_range(1, 300)) : 16'($urandom_range(0, 300));
      run_file("random_file", $urandom, 16'($urandom_range(1, 2000)), nb, tl, 4'($urandom_range(0, 1)),
               1, $urandom_range(1, 8));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] b = $urandom;
    logic [15:0] bd = 16'($urandom_range(1, 1500));
    clear_log();
    ready_mode = 1; auto_done = 1'b0;
    start_cfg(b, bd, 16'd6, 16'd0, 4'd0);
    repeat (50) @(negedge clk);
    tests_run++;
    if (cmd_addr_q.size() !== 4) begin tests_failed++; $display("FAIL bp_limit_count: got %0d expected 4", cmd_addr_q.size()); end
    tests_run++;
    if (o_tx_status[9:7] !== 3'd4) begin tests_failed++; $display("FAIL bp_outstanding: got %0d expected 4", o_tx_status[9:7]); end
    tests_run++;
    if (o_dma_cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_valid_low: got %b expected 0", o_dma_cmd_valid); end
    man_done_req = 2;
    repeat (40) @(negedge clk);
    tests_run++;
    if (cmd_addr_q.size() !== 6) begin tests_failed++; $display("FAIL bp_resume_count: got %0d expected 6", cmd_addr_q.size()); end
    tests_run++;
    if (o_tx_status[2:0] !== 3'd2) begin tests_failed++; $display("FAIL bp_state_wait: got %0d expected 2", o_tx_status[2:0]); end
    man_done_req = 4;
    wait_irq(200);
    check_file("backpressure", b, bd, 16'd6, 16'd0);
  endtask

  task automatic test_cfg_err();
    logic [15:0] bd [3];
    logic [15:0] nm [3];
    logic [15:0] tl [3];
    logic [3:0]  md [3];
    bd[0] = 16'd0;                        nm[0] = 16'd2;                       tl[0] = 16'($urandom_range(0, 300)); md[0] = 4'd0;
    bd[1] = 16'($urandom_range(1, 900));  nm[1] = 16'd0;                       tl[1] = 16'd0;                       md[1] = 4'd1;
    bd[2] = 16'($urandom_range(1, 900));  nm[2] = 16'($urandom_range(1, 4));   tl[2] = 16'($urandom_range(0, 300)); md[2] = 4'd5;
    for (int k = 0; k < 3; k++) begin
      clear_log();
      ready_mode = 0; auto_done = 1'b1; done_delay = 3;
      start_cfg($urandom, bd[k], nm[k], tl[k], md[k]);
      repeat (10) @(negedge clk);
      tests_run++;
      if (cmd_addr_q.size() !== 0 || irq_cnt !== 0) begin
        tests_failed++;
        $display("FAIL cfg_err%0d_activity: got cmds=%0d irqs=%0d expected 0/0", k, cmd_addr_q.size(), irq_cnt);
      end
      tests_run++;
      if ({o_tx_status[3], o_tx_status[2:0]} !== 4'b1_000) begin
        tests_failed++;
        $display("FAIL cfg_err%0d_status: got cfg_err=%b state=%0d expected 1/0", k, o_tx_status[3], o_tx_status[2:0]);
      end
    end
    run_file("after_cfg_err", $urandom, 16'd64, 16'd1, 16'd8, 4'd0, 0, 2);
    tests_run++;
    if (o_tx_status[3] !== 1'b0) begin tests_failed++; $display("FAIL cfg_err_cleared: got %b expected 0", o_tx_status[3]); end
  endtask

  task automatic test_overrun_simul_wrap();
    logic [31:0] b = $urandom;
    logic [15:0] bd = 16'($urandom_range(1, 2000));
    clear_log();
    ready_mode = 0; auto_done = 1'b0;
    start_cfg(b, bd, 16'd1, 16'd0, 4'd0);
    repeat (6) @(negedge clk);
    tests_run++;
    if (o_tx_status[2:0] !== 3'd2) begin tests_failed++; $display("FAIL ovr_in_wait: got state %0d expected 2", o_tx_status[2:0]); end
    start_cfg($urandom, 16'd32, 16'd2, 16'd0, 4'd2);
    repeat (3) @(negedge clk);
    tests_run++;
    if ({o_tx_status[4], o_tx_status[2:0], o_kcode_en} !== 5'b1_010_0) begin
      tests_failed++;
      $display("FAIL ovr_ignored: got overrun=%b state=%0d kcode=%b expected 1/2/0", o_tx_status[4], o_tx_status[2:0], o_kcode_en);
    end
    man_done_req = 1;
    wait_irq(50);
    check_file("overrun", b, bd, 16'd1, 16'd0);
    tests_run++;
    if (o_tx_status[4] !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky: got %b expected 1", o_tx_status[4]); end

    run_file("simultaneous", $urandom, 16'($urandom_range(1, 2000)), 16'd6, 16'd0, 4'd0, 0, 2);
    tests_run++;
    if (simul_cnt == 0 || simul_bad !== 0) begin
      tests_failed++;
      $display("FAIL simul_outstanding: got events=%0d changed=%0d expected >0/0", simul_cnt, simul_bad);
    end

    run_file("wrap", 32'hFFFF_FF00, 16'd512, 16'd2, 16'd0, 4'd0, 0, 3);
    tests_run++;
    if (cmd_addr_q.size() < 2) begin
      tests_failed++;
      $display("FAIL wrap_addr: got %0d commands expected 2", cmd_addr_q.size());
    end else if (cmd_addr_q[1] !== 32'h0000_0100) begin
      tests_failed++;
      $display("FAIL wrap_addr: got %h expected 00000100", cmd_addr_q[1]);
    end
  endtask

  task automatic test_kcode_reset();
    logic [31:0] b2 = $urandom;
    clear_log();
    ready_mode = 0; auto_done = 1'b0;
    start_cfg($urandom, 16'($urandom_range(1, 500)), 16'($urandom_range(1, 3)), 16'($urandom_range(0, 100)), 4'd2);
    repeat (10) @(negedge clk);
    tests_run++;
    if ({o_kcode_en, o_tx_status[6], o_tx_status[2:0], o_dma_cmd_valid} !== 6'b1_1_100_0 || cmd_addr_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL kcode_active: got kcode=%b stat6=%b state=%0d valid=%b cmds=%0d expected 1/1/4/0/0",
               o_kcode_en, o_tx_status[6], o_tx_status[2:0], o_dma_cmd_valid, cmd_addr_q.size());
    end
    ready_mode = 2;
    start_cfg(b2, 16'd16, 16'd1, 16'd0, 4'd0);
    @(negedge clk);
    tests_run++;
    if (o_kcode_en !== 1'b0) begin tests_failed++; $display("FAIL kcode_exit: got %b expected 0", o_kcode_en); end
    repeat (4) @(negedge clk);
    tests_run++;
    if ({o_dma_cmd_valid, o_dma_cmd_addr, o_dma_cmd_len, o_dma_cmd_last} !== {1'b1, b2, 16'd16, 1'b1}) begin
      tests_failed++;
      $display("FAIL kcode_cmd: got valid=%b addr=%h len=%0d last=%b expected 1/%h/16/1",
               o_dma_cmd_valid, o_dma_cmd_addr, o_dma_cmd_len, o_dma_cmd_last, b2);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_mid_issue");
    @(posedge clk); #1 rst = 1'b0; ready_mode = 0;
    repeat (20) @(negedge clk);
    tests_run++;
    if (cmd_addr_q.size() !== 0 || o_tx_status !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_forgets: got cmds=%0d status=%h expected 0/000", cmd_addr_q.size(), o_tx_status);
    end
  endtask

  task automatic test_watchdog();
`ifdef TX_SCHED_WDOG_EN
    int n = 0;
    clear_log();
    ready_mode = 0; auto_done = 1'b0;
    start_cfg($urandom, 16'($urandom_range(1, 2000)), 16'd1, 16'd0, 4'd0);
    while (to_cnt == 0 && n < 300) begin @(negedge clk); n++; end
    tests_run++;
    if (to_cnt == 0) begin
      tests_failed++;
      $display("FAIL wdog_fire: no o_timeout within 300 cycles");
    end else if (to_cyc !== hs_cyc + 100) begin
      tests_failed++;
      $display("FAIL wdog_latency: got cycle %0d expected %0d", to_cyc, hs_cyc + 100);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (to_cnt !== 1 || irq_cnt !== 0 || o_dma_cmd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wdog_pulse: got timeouts=%0d irqs=%0d valid=%b expected 1/0/0", to_cnt, irq_cnt, o_dma_cmd_valid);
    end
    tests_run++;
    if ({o_tx_status[9:7], o_tx_status[3], o_tx_status[2:0]} !== 7'b000_1_000) begin
      tests_failed++;
      $display("FAIL wdog_status: got outst=%0d cfg_err=%b state=%0d expected 0/1/0",
               o_tx_status[9:7], o_tx_status[3], o_tx_status[2:0]);
    end
`else
    tests_run++;
    if (to_total !== 0) begin tests_failed++; $display("FAIL timeout_tied: got %0d pulses expected 0", to_total); end
`endif
  endtask

  initial begin
    clear_log();
    test_reset();
    test_nominal();
    test_backpressure();
    test_cfg_err();
    test_overrun_simul_wrap();
    test_kcode_reset();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
